// File: rtl/spi_poci_shifter_if.sv
// Signal bundle between the SPI read-path shifter and its register sources / POCI pin.
// The slave side is the shifter; the master side is whatever owns the registers and pins.
interface spi_poci_shifter_if;
   logic       serial_in;
   logic [7:0] trigger_channel_mask;
   logic [7:0] instruction;
   logic [7:0] mode;
   logic [7:0] analog_rd_data;
   logic [7:0] rd_addr;
   logic       data_phase;
   logic       serial_out;

   modport slave (
      input  serial_in,
      input  trigger_channel_mask,
      input  instruction,
      input  mode,
      input  analog_rd_data,
      output rd_addr,
      output data_phase,
      output serial_out
   );

   modport master (
      output serial_in,
      output trigger_channel_mask,
      output instruction,
      output mode,
      output analog_rd_data,
      input  rd_addr,
      input  data_phase,
      input  serial_out
   );
endinterface

// File: rtl/spi_poci_shifter.sv
// SPI read path: captures the start address from the first byte of a frame, then streams
// register bytes MSB first on POCI from an auto-incrementing, saturating read pointer.
module spi_poci_shifter #(
   parameter int MAX_ADDR = 59
) (
   input  logic               sclk,
   input  logic               rstn,
   spi_poci_shifter_if.slave  bus
);

   localparam logic [0:0] ST_ADDR = 1'b0;
   localparam logic [0:0] ST_DATA = 1'b1;
   localparam logic [7:0] MAX_A   = 8'(MAX_ADDR);

   logic [2:0] bit_cnt;
   logic [0:0] state;
   logic [6:0] addr_sr;
   logic [7:0] shift_reg;
   logic [7:0] rd_addr;
   logic       data_phase;

   // Address 0 and anything past the bank read as zero.
   function automatic logic [7:0] sel_src(
      input logic [7:0] a,
      input logic [7:0] mask,
      input logic [7:0] instr,
      input logic [7:0] md,
      input logic [7:0] analog
   );
      if (a == 8'd1)
         return mask;
      else if (a == 8'd2)
         return instr;
      else if (a == 8'd3)
         return md;
      else if (a >= 8'd4 && a <= MAX_A)
         return analog;
      else
         return 8'h00;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] a);
      return (a == 8'hFF) ? a : a + 8'd1;
   endfunction

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         bit_cnt    <= 3'd0;
         state      <= ST_ADDR;
         addr_sr    <= 7'd0;
         shift_reg  <= 8'h00;
         rd_addr    <= 8'h00;
         data_phase <= 1'b0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         case (state)
            ST_ADDR: begin
               addr_sr <= {addr_sr[5:0], bus.serial_in};
               if (bit_cnt == 3'd7) begin
                  rd_addr    <= {addr_sr, bus.serial_in};
                  state      <= ST_DATA;
                  data_phase <= 1'b1;
               end
            end
            default: begin
               // Sources are sampled only here, so mid-byte changes never reach the wire.
               if (bit_cnt == 3'd0) begin
                  shift_reg <= sel_src(rd_addr, bus.trigger_channel_mask, bus.instruction,
                                       bus.mode, bus.analog_rd_data);
                  rd_addr   <= sat_inc(rd_addr);
               end else begin
                  shift_reg <= {shift_reg[6:0], 1'b0};
               end
            end
         endcase
      end
   end

   assign bus.rd_addr    = rd_addr;
   assign bus.data_phase = data_phase;
   assign bus.serial_out = data_phase & shift_reg[7];

endmodule
